// File: rtl/memoria_datos_es.sv
// Data-side memory map for the processor: 8-bit RAM below IO_BASE plus an I/O bank
// (output port, synchronised input with change detect, prescaled timer, sticky status).
module memoria_datos_es #(
    parameter logic [7:0] IO_BASE   = 8'hF0,
    parameter int         PRESC_DIV = 4
) (
    input  logic       Clk,
    input  logic       Rst,
    input  logic [7:0] Direccion_Datos,
    input  logic [7:0] Salida_Datos,
    input  logic       RW,
    output logic [7:0] Datos_Entrada,
    input  logic [7:0] Puerto_Entrada,
    output logic [7:0] Puerto_Salida,
    output logic       Evento
);

    localparam int            PW   = (PRESC_DIV > 1) ? $clog2(PRESC_DIV) : 1;
    localparam logic [PW-1:0] PMAX = PW'(PRESC_DIV - 1);

    logic [7:0]    r_ram [0:IO_BASE-1];
    logic [7:0]    r_out;
    logic [7:0]    r_s1;
    logic [7:0]    r_s2;
    logic [7:0]    r_s3;
    logic [1:0]    r_stat;
    logic [7:0]    r_tcnt;
    logic [7:0]    r_trld;
    logic [7:0]    r_tctl;
    logic [PW-1:0] r_presc;

    logic       w_is_ram;
    logic [7:0] w_off;
    logic       w_wr_io;
    logic       w_wr_out;
    logic       w_wr_stat;
    logic       w_wr_tcnt;
    logic       w_wr_trld;
    logic       w_wr_tctl;
    logic       w_tick;
    logic       w_ovf;
    logic       w_chg;
    logic [1:0] w_stat_clr;

    assign w_is_ram  = (Direccion_Datos < IO_BASE);
    assign w_off     = Direccion_Datos - IO_BASE;
    assign w_wr_io   = RW && !w_is_ram;
    assign w_wr_out  = w_wr_io && (w_off == 8'd0);
    assign w_wr_stat = w_wr_io && (w_off == 8'd2);
    assign w_wr_tcnt = w_wr_io && (w_off == 8'd3);
    assign w_wr_trld = w_wr_io && (w_off == 8'd4);
    assign w_wr_tctl = w_wr_io && (w_off == 8'd5);

    // A CPU write to TCNT swallows a coincident tick, including its overflow flag.
    assign w_tick     = r_tctl[0] && (r_presc == PMAX);
    assign w_ovf      = w_tick && (r_tcnt == 8'hFF) && !w_wr_tcnt;
    assign w_chg      = (r_s2 != r_s3);
    assign w_stat_clr = w_wr_stat ? Salida_Datos[1:0] : 2'b00;

    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_out   <= 8'h00;
            r_s1    <= 8'h00;
            r_s2    <= 8'h00;
            r_s3    <= 8'h00;
            r_stat  <= 2'b00;
            r_tcnt  <= 8'h00;
            r_trld  <= 8'h00;
            r_tctl  <= 8'h00;
            r_presc <= '0;
        end else begin
            r_s1 <= Puerto_Entrada;
            r_s2 <= r_s1;
            r_s3 <= r_s2;
            if (r_tctl[0]) begin
                r_presc <= (r_presc == PMAX) ? '0 : r_presc + 1'b1;
            end
            // Set events take priority over a same-cycle write-one-to-clear.
            r_stat <= (r_stat & ~w_stat_clr) | {w_ovf, w_chg};
            if (w_wr_tcnt) begin
                r_tcnt <= Salida_Datos;
            end else if (w_tick) begin
                if (r_tcnt == 8'hFF) begin
                    r_tcnt <= r_tctl[1] ? r_trld : 8'h00;
                end else begin
                    r_tcnt <= r_tcnt + 8'd1;
                end
            end
            if (w_wr_out) begin
                r_out <= Salida_Datos;
            end
            if (w_wr_trld) begin
                r_trld <= Salida_Datos;
            end
            if (w_wr_tctl) begin
                r_tctl <= Salida_Datos;
            end
        end
    end

    // RAM has no reset; a write coinciding with reset is still suppressed.
    always_ff @(posedge Clk) begin
        if (RW && w_is_ram && !Rst) begin
            r_ram[Direccion_Datos] <= Salida_Datos;
        end
    end

    always_comb begin
        Datos_Entrada = 8'h00;
        if (w_is_ram) begin
            Datos_Entrada = r_ram[Direccion_Datos];
        end else begin
            case (w_off)
                8'd0:    Datos_Entrada = r_out;
                8'd1:    Datos_Entrada = r_s2;
                8'd2:    Datos_Entrada = {6'b000000, r_stat};
                8'd3:    Datos_Entrada = r_tcnt;
                8'd4:    Datos_Entrada = r_trld;
                8'd5:    Datos_Entrada = r_tctl;
                default: Datos_Entrada = 8'h00;
            endcase
        end
    end

    assign Puerto_Salida = r_out;
    assign Evento        = (r_stat[0] & r_tctl[2]) | (r_stat[1] & r_tctl[3]);

endmodule

// File: tb/tb_memoria_datos_es.sv
// Bench for memoria_datos_es: directed map/timer/collision checks with literal
// expectations, then randomized traffic compared every cycle against a reference model.
module tb_memoria_datos_es;

    localparam int PRESC_DIV = 4;

    logic       clk;
    logic       rst;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic       rw;
    logic [7:0] rdata;
    logic [7:0] pin;
    logic [7:0] pout;
    logic       evento;

    int n_checks = 0;
    int n_fail   = 0;
    bit cmp_en   = 0;

    memoria_datos_es #(.IO_BASE(8'hF0), .PRESC_DIV(PRESC_DIV)) dut (
        .Clk(clk),
        .Rst(rst),
        .Direccion_Datos(addr),
        .Salida_Datos(wdata),
        .RW(rw),
        .Datos_Entrada(rdata),
        .Puerto_Entrada(pin),
        .Puerto_Salida(pout),
        .Evento(evento)
    );

    initial clk = 0;
    always #5 clk = ~clk;

    // Reference model: plain state variables and the memory map rules.
    logic [7:0] m_ram [0:255];
    bit         m_known [0:255];
    int unsigned m_out, m_s1, m_s2, m_s3, m_stat, m_tcnt, m_trld, m_tctl, m_presc;

    initial begin
        for (int i = 0; i < 256; i++) m_known[i] = 0;
        m_out = 0; m_s1 = 0; m_s2 = 0; m_s3 = 0; m_stat = 0;
        m_tcnt = 0; m_trld = 0; m_tctl = 0; m_presc = 0;
    end

    function automatic int model_read(input int a);
        if (a < 'hF0) return m_known[a] ? int'(m_ram[a]) : -1;
        case (a)
            'hF0: return int'(m_out);
            'hF1: return int'(m_s2);
            'hF2: return int'(m_stat);
            'hF3: return int'(m_tcnt);
            'hF4: return int'(m_trld);
            'hF5: return int'(m_tctl);
            default: return 0;
        endcase
    endfunction

    always @(posedge clk) begin
        int a, d;
        bit tick, wr_tcnt, chg, ovf;
        int unsigned next_tcnt, clr;
        a = int'(addr);
        d = int'(wdata);
        if (rst) begin
            m_out = 0; m_s1 = 0; m_s2 = 0; m_s3 = 0; m_stat = 0;
            m_tcnt = 0; m_trld = 0; m_tctl = 0; m_presc = 0;
        end else begin
            tick    = (m_tctl % 2 == 1) && (m_presc == PRESC_DIV - 1);
            wr_tcnt = rw && a == 'hF3;
            chg     = (m_s2 != m_s3);
            ovf     = tick && m_tcnt == 255 && !wr_tcnt;
            if (wr_tcnt) next_tcnt = d;
            else if (tick) next_tcnt = (m_tcnt == 255) ? (((m_tctl / 2) % 2 == 1) ? m_trld : 0) : m_tcnt + 1;
            else next_tcnt = m_tcnt;
            clr = (rw && a == 'hF2) ? (d % 4) : 0;
            m_stat = ((m_stat & ~clr) & 3) | (ovf ? 2 : 0) | (chg ? 1 : 0);
            if (m_tctl % 2 == 1) m_presc = (m_presc + 1) % PRESC_DIV;
            m_tcnt = next_tcnt;
            m_s3 = m_s2; m_s2 = m_s1; m_s1 = pin;
            if (rw) begin
                if (a < 'hF0) begin m_ram[a] = wdata; m_known[a] = 1; end
                if (a == 'hF0) m_out = d;
                if (a == 'hF4) m_trld = d;
                if (a == 'hF5) m_tctl = d;
            end
        end
    end

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Compare process: every negedge once reset is done.
    always @(negedge clk) begin
        int e;
        if (cmp_en) begin
            e = model_read(int'(addr));
            if (e >= 0) check("model_rdata", int'(rdata), e);
            check("model_pout", int'(pout), int'(m_out));
            check("model_evento", int'(evento),
                  int'(((m_stat % 2) & ((m_tctl / 4) % 2)) | (((m_stat / 2) % 2) & ((m_tctl / 8) % 2))));
        end
    end

    task automatic idle(input int n);
        rw = 0;
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic wr(input logic [7:0] a, input logic [7:0] d);
        addr = a; wdata = d; rw = 1;
        @(posedge clk); #1;
        rw = 0;
    endtask

    task automatic rd_chk(input string name, input logic [7:0] a, input logic [7:0] exp);
        addr = a; rw = 0;
        #1;
        check(name, int'(rdata), int'(exp));
    endtask

    initial begin
        rst = 1; addr = 8'h00; wdata = 8'h00; rw = 0; pin = 8'h00;
        repeat (2) begin @(posedge clk); #1; end
        rst = 0;
        cmp_en = 1;
        for (int a = 'hF0; a <= 'hFF; a++) rd_chk("reset_io", 8'(a), 8'h00);
        check("reset_pout", int'(pout), 0);
        check("reset_evento", int'(evento), 0);

        wr(8'h10, 8'hA5);
        wr(8'hEF, 8'h5A);
        rd_chk("ram_10", 8'h10, 8'hA5);
        rd_chk("ram_ef", 8'hEF, 8'h5A);
        wr(8'hF8, 8'h77);
        rd_chk("unmapped_f8", 8'hF8, 8'h00);
        wr(8'hF1, 8'h55);
        rd_chk("in_write_ignored", 8'hF1, 8'h00);

        wr(8'hF0, 8'h3C);
        check("out_port", int'(pout), 'h3C);
        rd_chk("out_read", 8'hF0, 8'h3C);

        pin = 8'h81;
        idle(2);
        rd_chk("in_sync", 8'hF1, 8'h81);
        rd_chk("stat_not_yet", 8'hF2, 8'h00);
        idle(1);
        rd_chk("stat_chg", 8'hF2, 8'h01);
        wr(8'hF5, 8'h04);
        check("evento_chg", int'(evento), 1);
        wr(8'hF2, 8'h01);
        rd_chk("stat_w1c", 8'hF2, 8'h00);
        check("evento_clr", int'(evento), 0);

        wr(8'hF4, 8'hF0);
        wr(8'hF3, 8'hFE);
        wr(8'hF5, 8'h0B);
        idle(3);
        rd_chk("tcnt_hold", 8'hF3, 8'hFE);
        idle(1);
        rd_chk("tcnt_ff", 8'hF3, 8'hFF);
        idle(3);
        wr(8'hF2, 8'h02);   // W1C on the overflow edge
        rd_chk("tcnt_reload", 8'hF3, 8'hF0);
        rd_chk("stat_ovf_set_wins", 8'hF2, 8'h02);
        check("evento_ovf", int'(evento), 1);
        idle(3);
        wr(8'hF3, 8'h20);   // TCNT write on a tick edge
        rd_chk("tcnt_write_wins", 8'hF3, 8'h20);
        idle(3);
        rd_chk("tcnt_after_lost", 8'hF3, 8'h20);
        idle(1);
        rd_chk("tcnt_next_tick", 8'hF3, 8'h21);

        addr = 8'hF0; wdata = 8'hEE; rw = 1; rst = 1;
        @(posedge clk); #1;
        rst = 0; rw = 0;
        check("rst_over_write", int'(pout), 0);
        rd_chk("rst_tctl", 8'hF5, 8'h00);

        for (int c = 0; c < 4000; c++) begin
            if ($urandom_range(0, 7) == 0) pin = 8'($urandom);
            rw    = ($urandom_range(0, 2) == 0);
            addr  = ($urandom_range(0, 1) == 0) ? 8'($urandom_range('hF0, 'hFF)) : 8'($urandom_range(0, 'hEF));
            wdata = 8'($urandom);
            if (addr == 8'hF3 && $urandom_range(0, 1) == 0) wdata = 8'($urandom_range('hFC, 'hFF));
            rst   = ($urandom_range(0, 499) == 0);
            @(posedge clk); #1;
        end
        rst = 0; rw = 0;
        idle(2);
        cmp_en = 0;
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
